// File: rtl/spi_peripheral_pkg.sv
// spi_peripheral_pkg: shared definitions for the SPI peripheral.
// Holds the gpioOut field positions, frame lengths, status bit positions,
// the FSM state encoding and the per-frame configuration record.
package spi_peripheral_pkg;

  // gpioOut field positions
  localparam int unsigned LSB_FIRST_BIT = 30;
  localparam int unsigned CPOL_BIT      = 29;
  localparam int unsigned CPHA_BIT      = 28;
  localparam int unsigned DATA_WIDTH    = 24;

  // Accepted frame lengths in bits
  localparam int unsigned SHORT_FRAME = 16;
  localparam int unsigned LONG_FRAME  = 24;

  // status word bit positions
  localparam int unsigned STATUS_FRAME_ACTIVE  = 31;
  localparam int unsigned STATUS_FRAME_ERROR   = 30;
  localparam int unsigned STATUS_RX_LARGE      = 29;
  localparam int unsigned STATUS_BIT_COUNT_LSB = 24;
  localparam int unsigned BIT_COUNT_WIDTH      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic                  lsb_first;
    logic                  cpol;
    logic                  cpha;
    logic [DATA_WIDTH-1:0] tx;
  } cfg_t;

endpackage

// File: rtl/spi_peripheral_sync.sv
// spi_peripheral_sync: input synchronizer for one SPI pin.
//   clk, reset : fabric clock, synchronous active-high reset
//   din        : asynchronous pin
//   level      : synchronized (optionally filtered) level
//   rise, fall : single-cycle edge indications on level
// With SPI_PERIPHERAL_DEGLITCH_EN defined, a 3-sample majority filter
// follows the synchronizer when FILTER=1; FILTER=0 gets a plain delay of
// the same length so that unfiltered pins stay aligned with filtered ones.
module spi_peripheral_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          FILTER      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef SPI_PERIPHERAL_DEGLITCH_EN
  logic [1:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], synced};
      if (FILTER)
        filt_q <= (synced & hist_q[0]) | (synced & hist_q[1]) | (hist_q[0] & hist_q[1]);
      else
        filt_q <= hist_q[0];
    end
  end

  assign level = filt_q;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI target for analog front-end control links.
//   clk, reset          : fabric clock, synchronous active-high reset
//   csrStrobe, gpioOut  : host loads pending config {lsbFirst, cpol, cpha, tx word}
//   status              : {frameActive, lastFrameError, rxLarge, lastBitCount, rxData}
//   rxData, rxValid     : last good frame (right-aligned) and its one-clk pulse
//   SPI_CLK/CSB/SDI     : SPI pins from the master
//   SPI_SDO, SPI_SDO_OE : MISO and its drive enable
// Optional macro SPI_PERIPHERAL_DEGLITCH_EN adds a majority filter on
// SPI_CLK/SPI_CSB (two extra clk of latency, stricter rate check).
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int unsigned CLK_RATE     = 100000000,
  parameter int unsigned MAX_BIT_RATE = 12500000,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter string       DEBUG        = "false"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csrStrobe,
  input  logic [31:0] gpioOut,
  output logic [31:0] status,
  output logic [23:0] rxData,
  output logic        rxValid,
  input  logic        SPI_CLK,
  input  logic        SPI_CSB,
  input  logic        SPI_SDI,
  output logic        SPI_SDO,
  output logic        SPI_SDO_OE
);

`ifdef SPI_PERIPHERAL_DEGLITCH_EN
  localparam longint unsigned MIN_RATIO = 12;
`else
  localparam longint unsigned MIN_RATIO = 8;
`endif

  if (longint'(CLK_RATE) < MIN_RATIO * longint'(MAX_BIT_RATE)) begin : g_bad_rate
    $error("CLK_RATE too low for MAX_BIT_RATE");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBUG != "true" && DEBUG != "false") begin : g_bad_debug
    $error("DEBUG must be \"true\" or \"false\"");
  end

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic csb_level, csb_rise, csb_fall;
  logic sdi_level, sdi_rise_unused, sdi_fall_unused;
  logic unused_gpio;

  spi_peripheral_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b1)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(SPI_CLK),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

  spi_peripheral_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b1)) u_sync_csb (
    .clk(clk), .reset(reset), .din(SPI_CSB),
    .level(csb_level), .rise(csb_rise), .fall(csb_fall));

  spi_peripheral_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER(1'b0)) u_sync_sdi (
    .clk(clk), .reset(reset), .din(SPI_SDI),
    .level(sdi_level), .rise(sdi_rise_unused), .fall(sdi_fall_unused));

  assign unused_gpio = ^{gpioOut[31], gpioOut[27:24]};

  state_t                     state_q, state_d;
  cfg_t                       pend_q, act_q, strobe_cfg, next_cfg;
  logic [DATA_WIDTH-1:0]      tx_shift_q, rx_shift_q, rx_data_q;
  logic [BIT_COUNT_WIDTH-1:0] bit_count_q, last_count_q;
  logic [7:0]                 error_count_q;
  logic                       first_launch_q, armed_q;
  logic                       rx_valid_q, frame_err_q, rx_large_q;
  logic                       sdo_oe;
  logic                       lead_edge, trail_edge, sample_edge, launch_edge;

  always_comb begin
    strobe_cfg           = '0;
    strobe_cfg.lsb_first = gpioOut[LSB_FIRST_BIT];
    strobe_cfg.cpol      = gpioOut[CPOL_BIT];
    strobe_cfg.cpha      = gpioOut[CPHA_BIT];
    strobe_cfg.tx        = gpioOut[DATA_WIDTH-1:0];
  end

  // A strobe coinciding with the CSB fall takes effect for that frame.
  assign next_cfg = csrStrobe ? strobe_cfg : pend_q;

  assign lead_edge   = act_q.cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = act_q.cpol ? sclk_rise : sclk_fall;
  assign sample_edge = act_q.cpha ? trail_edge : lead_edge;
  assign launch_edge = act_q.cpha ? lead_edge : trail_edge;

  always_comb begin
    state_d = state_q;
    sdo_oe  = 1'b0;
    unique case (state_q)
      IDLE:  if (csb_fall && armed_q) state_d = SHIFT;
      SHIFT: begin
        sdo_oe = 1'b1;
        if (csb_rise) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      pend_q         <= '0;
      act_q          <= '0;
      tx_shift_q     <= '0;
      rx_shift_q     <= '0;
      rx_data_q      <= '0;
      bit_count_q    <= '0;
      last_count_q   <= '0;
      error_count_q  <= '0;
      first_launch_q <= 1'b0;
      armed_q        <= 1'b0;
      rx_valid_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      rx_large_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_q | csb_level;
      rx_valid_q <= 1'b0;
      if (csrStrobe) pend_q <= strobe_cfg;

      unique case (state_q)
        IDLE: begin
          if (csb_fall) act_q <= next_cfg;
          if (csb_fall && armed_q) begin
            tx_shift_q     <= next_cfg.tx;
            rx_shift_q     <= '0;
            bit_count_q    <= '0;
            first_launch_q <= 1'b1;
          end
        end
        SHIFT: begin
          // An SCLK edge in the same cycle as the CSB rise is discarded.
          if (!csb_rise) begin
            if (sample_edge) begin
              rx_shift_q <= act_q.lsb_first ? {sdi_level, rx_shift_q[DATA_WIDTH-1:1]}
                                            : {rx_shift_q[DATA_WIDTH-2:0], sdi_level};
              if (bit_count_q != '1) bit_count_q <= bit_count_q + 5'd1;
            end
            if (launch_edge) begin
              first_launch_q <= 1'b0;
              // cpha=1: the first leading edge only presents bit 0.
              if (!(act_q.cpha && first_launch_q))
                tx_shift_q <= act_q.lsb_first ? (tx_shift_q >> 1) : (tx_shift_q << 1);
            end
          end
        end
        DONE: begin
          last_count_q <= bit_count_q;
          if (bit_count_q == 5'(LONG_FRAME)) begin
            rx_data_q   <= rx_shift_q;
            rx_large_q  <= 1'b1;
            rx_valid_q  <= 1'b1;
            frame_err_q <= 1'b0;
          end else if (bit_count_q == 5'(SHORT_FRAME)) begin
            rx_data_q   <= act_q.lsb_first ? {8'h00, rx_shift_q[23:8]} : {8'h00, rx_shift_q[15:0]};
            rx_large_q  <= 1'b0;
            rx_valid_q  <= 1'b1;
            frame_err_q <= 1'b0;
          end else begin
            frame_err_q <= 1'b1;
            if (error_count_q != '1) error_count_q <= error_count_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status                                                 = '0;
    status[STATUS_FRAME_ACTIVE]                            = (state_q == SHIFT);
    status[STATUS_FRAME_ERROR]                             = frame_err_q;
    status[STATUS_RX_LARGE]                                = rx_large_q;
    status[STATUS_BIT_COUNT_LSB +: BIT_COUNT_WIDTH]        = last_count_q;
    status[DATA_WIDTH-1:0]                                 = rx_data_q;
  end

  assign rxData     = rx_data_q;
  assign rxValid    = rx_valid_q;
  assign SPI_SDO_OE = sdo_oe;
  assign SPI_SDO    = sdo_oe & (act_q.lsb_first ? tx_shift_q[0] : tx_shift_q[DATA_WIDTH-1]);

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench for spi_peripheral. A behavioural SPI
// master drives frames at the maximum bit rate (8 fabric clk per bit) and
// collects MISO; expected values are hand-computed constants.
module tb_spi_peripheral;

  logic        clk = 1'b0;
  logic        reset;
  logic        csrStrobe;
  logic [31:0] gpioOut;
  logic [31:0] status;
  logic [23:0] rxData;
  logic        rxValid;
  logic        SPI_CLK, SPI_CSB, SPI_SDI;
  logic        SPI_SDO, SPI_SDO_OE;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int bad_pre = 0;
  int bad_post = 0;

  spi_peripheral #(
    .CLK_RATE(100000000),
    .MAX_BIT_RATE(12500000),
    .SYNC_STAGES(2),
    .DEBUG("false")
  ) dut (
    .clk(clk), .reset(reset), .csrStrobe(csrStrobe), .gpioOut(gpioOut),
    .status(status), .rxData(rxData), .rxValid(rxValid),
    .SPI_CLK(SPI_CLK), .SPI_CSB(SPI_CSB), .SPI_SDI(SPI_SDI),
    .SPI_SDO(SPI_SDO), .SPI_SDO_OE(SPI_SDO_OE)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rxValid === 1'b1) valid_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_cfg(input logic lsb, input logic cpol, input logic cpha, input logic [23:0] tx);
    @(negedge clk);
    gpioOut   = {1'b0, lsb, cpol, cpha, 4'h0, tx};
    csrStrobe = 1'b1;
    @(negedge clk);
    csrStrobe = 1'b0;
  endtask

  task automatic half_bit();
    repeat (4) @(negedge clk);
  endtask

  // Samples DUT drive state at each master sample point.
  task automatic note_drive(input bit after_reset);
    if (!after_reset) begin
      if (SPI_SDO_OE !== 1'b1 || status[31] !== 1'b1) bad_pre++;
    end else if (SPI_SDO_OE !== 1'b0) bad_post++;
  endtask

  task automatic spi_frame(input logic cpol, input logic cpha, input logic lsb, input int nbits,
                           input logic [23:0] mosi_word, input int strobe_bit,
                           input logic [31:0] strobe_word, input int reset_bit,
                           output logic [23:0] miso_word);
    bit rst_done = 1'b0;
    int idx;
    miso_word = '0;
    bad_pre   = 0;
    bad_post  = 0;
    @(negedge clk);
    SPI_CLK = cpol;
    half_bit();
    idx = lsb ? 0 : nbits - 1;
    if (!cpha) SPI_SDI = mosi_word[idx];
    SPI_CSB = 1'b0;
    half_bit();
    half_bit();
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : nbits - 1 - i;
      if (i == strobe_bit) begin
        gpioOut   = strobe_word;
        csrStrobe = 1'b1;
        @(negedge clk);
        csrStrobe = 1'b0;
      end
      if (i == reset_bit) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rst_done = 1'b1;
      end
      if (cpha) begin
        SPI_CLK = ~cpol;
        SPI_SDI = mosi_word[idx];
      end else begin
        miso_word[idx] = SPI_SDO;
        note_drive(rst_done);
        SPI_CLK = ~cpol;
      end
      half_bit();
      if (cpha) begin
        miso_word[idx] = SPI_SDO;
        note_drive(rst_done);
        SPI_CLK = cpol;
      end else begin
        SPI_CLK = cpol;
        if (i + 1 < nbits) SPI_SDI = mosi_word[lsb ? i + 1 : nbits - 2 - i];
      end
      half_bit();
    end
    half_bit();
    SPI_CSB = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  logic [23:0] miso;
  int          v0;

  initial begin
    reset = 1'b1; csrStrobe = 1'b0; gpioOut = '0;
    SPI_CLK = 1'b0; SPI_CSB = 1'b1; SPI_SDI = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_status",  status,           32'h0);
    check("rst_rxdata",  {8'h0, rxData},   32'h0);
    check("rst_rxvalid", {31'h0, rxValid}, 32'h0);
    check("rst_oe",      {31'h0, SPI_SDO_OE}, 32'h0);
    check("rst_sdo",     {31'h0, SPI_SDO}, 32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Mode 0, MSB-first, 24-bit
    load_cfg(1'b0, 1'b0, 1'b0, 24'hA5C3F0);
    v0 = valid_cnt;
    spi_frame(1'b0, 1'b0, 1'b0, 24, 24'h123456, -1, 32'h0, -1, miso);
    check("m0_rx",     {8'h0, rxData}, 32'h00123456);
    check("m0_miso",   {8'h0, miso},   32'h00A5C3F0);
    check("m0_valid",  valid_cnt - v0, 32'd1);
    check("m0_status", status,         32'h38123456);
    check("m0_drive",  bad_pre,        32'd0);

    // SCLK toggling with CSB high must be ignored
    for (int k = 0; k < 6; k++) begin
      SPI_CLK = ~SPI_CLK;
      half_bit();
    end

    // Mode 3, LSB-first, 16-bit
    load_cfg(1'b1, 1'b1, 1'b1, 24'h00CAFE);
    v0 = valid_cnt;
    spi_frame(1'b1, 1'b1, 1'b1, 16, 24'h00BEEF, -1, 32'h0, -1, miso);
    check("m3_rx",     {8'h0, rxData}, 32'h0000BEEF);
    check("m3_miso",   {8'h0, miso},   32'h0000CAFE);
    check("m3_valid",  valid_cnt - v0, 32'd1);
    check("m3_status", status,         32'h1000BEEF);

    // Mode 1, MSB-first, 24-bit
    load_cfg(1'b0, 1'b0, 1'b1, 24'h0F1E2D);
    v0 = valid_cnt;
    spi_frame(1'b0, 1'b1, 1'b0, 24, 24'h5A5A5A, -1, 32'h0, -1, miso);
    check("m1_rx",    {8'h0, rxData}, 32'h005A5A5A);
    check("m1_miso",  {8'h0, miso},   32'h000F1E2D);
    check("m1_valid", valid_cnt - v0, 32'd1);
    check("m1_drive", bad_pre,        32'd0);

    // Mode 2, MSB-first, 24-bit
    load_cfg(1'b0, 1'b1, 1'b0, 24'hC0FFEE);
    v0 = valid_cnt;
    spi_frame(1'b1, 1'b0, 1'b0, 24, 24'h5A5A5A, -1, 32'h0, -1, miso);
    check("m2_rx",    {8'h0, rxData}, 32'h005A5A5A);
    check("m2_miso",  {8'h0, miso},   32'h00C0FFEE);
    check("m2_valid", valid_cnt - v0, 32'd1);

    // 20-bit frame is rejected, then a 16-bit frame clears the error
    load_cfg(1'b0, 1'b0, 1'b0, 24'h777700);
    v0 = valid_cnt;
    spi_frame(1'b0, 1'b0, 1'b0, 20, 24'h0ABCDE, -1, 32'h0, -1, miso);
    check("e20_valid",  valid_cnt - v0,          32'd0);
    check("e20_err",    {31'h0, status[30]},     32'd1);
    check("e20_bitcnt", {27'h0, status[28:24]},  32'd20);
    check("e20_rx",     {8'h0, rxData},          32'h005A5A5A);
    v0 = valid_cnt;
    spi_frame(1'b0, 1'b0, 1'b0, 16, 24'h001234, -1, 32'h0, -1, miso);
    check("s16_valid",  valid_cnt - v0, 32'd1);
    check("s16_status", status,         32'h10001234);
    check("s16_miso",   {8'h0, miso},   32'h00007777);

    // Strobe mid-frame affects only the next frame
    load_cfg(1'b0, 1'b0, 1'b0, 24'h111111);
    spi_frame(1'b0, 1'b0, 1'b0, 24, 24'hF00F00, 8, 32'h00222222, -1, miso);
    check("strobe_old",    {8'h0, miso},   32'h00111111);
    check("strobe_old_rx", {8'h0, rxData}, 32'h00F00F00);
    spi_frame(1'b0, 1'b0, 1'b0, 24, 24'h00FF00, -1, 32'h0, -1, miso);
    check("strobe_new",    {8'h0, miso},   32'h00222222);
    check("strobe_new_rx", {8'h0, rxData}, 32'h0000FF00);

    // Reset during bit 10 with CSB low
    load_cfg(1'b0, 1'b0, 1'b0, 24'h999999);
    v0 = valid_cnt;
    spi_frame(1'b0, 1'b0, 1'b0, 24, 24'h13579B, -1, 32'h0, 10, miso);
    check("rst_mid_valid",  valid_cnt - v0, 32'd0);
    check("rst_mid_oe",     bad_post,       32'd0);
    check("rst_mid_pre",    bad_pre,        32'd0);
    check("rst_mid_status", status,         32'h0);
    load_cfg(1'b0, 1'b0, 1'b0, 24'h3C5A96);
    v0 = valid_cnt;
    spi_frame(1'b0, 1'b0, 1'b0, 24, 24'h0F0F0F, -1, 32'h0, -1, miso);
    check("post_rst_rx",    {8'h0, rxData}, 32'h000F0F0F);
    check("post_rst_miso",  {8'h0, miso},   32'h003C5A96);
    check("post_rst_valid", valid_cnt - v0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
